alu32_serial_addsub: RTL

//  Multi-cycle 32-bit add/subtract unit that time-multiplexes one 4-bit CLA slice with overflow taps
//  (cla4_ov: a, b, ci -> s, c3, co) across WIDTH/4 cycles. It feeds the slice one nibble per cycle,

---
 rtl/alu32_serial_addsub.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu32_serial_addsub.sv
// Serial add/subtract unit: one 4-bit CLA slice reused across WIDTH/4 cycles.
// Operands are latched on accept. Each RUN cycle consumes one nibble, LSB first.
// The full result and the N/Z/C/V flags are registered when the final nibble completes.

// 4-bit carry-lookahead slice with taps for the carry into and out of the MSB
module cla4_ov (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       co
);
  logic [3:0] p, g;
  logic       c1, c2;

  // Flat lookahead equations; c3 is the carry into bit 3 and feeds the overflow tap
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
  end
endmodule

module alu32_serial_addsub #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_n,
  output logic             o_z,
  output logic             o_c,
  output logic             o_v
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       sum_nib;
  logic             c3_nib, co_nib;
  logic             accept, last;
  logic [WIDTH-1:0] final_res;

  cla4_ov u_slice (
    .a  (a_reg[3:0]),
    .b  (b_reg[3:0]),
    .ci (carry),
    .s  (sum_nib),
    .c3 (c3_nib),
    .co (co_nib)
  );

  // A new op may start from IDLE or from the DONE cycle (back-to-back), never mid-RUN
  always_comb begin
    accept    = i_start && (state != RUN);
    last      = (state == RUN) && (cnt == CW'(NIB - 1));
    final_res = {sum_nib, acc[WIDTH-1:4]};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: RUN for exactly NIB cycles, then a single DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry chain and nibble accumulator.
  // Subtraction is a + ~b + 1: B is inverted on accept and the carry seeds to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      a_reg <= i_a;
      b_reg <= i_b ^ {WIDTH{i_op}};
      carry <= i_op;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_reg <= {4'b0, a_reg[WIDTH-1:4]};
      b_reg <= {4'b0, b_reg[WIDTH-1:4]};
      acc   <= final_res;
      carry <= co_nib;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result and flags change only when the last nibble lands, so partial sums never show
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_result <= '0;
      o_n      <= 1'b0;
      o_z      <= 1'b0;
      o_c      <= 1'b0;
      o_v      <= 1'b0;
    end else if (last) begin
      o_result <= final_res;
      o_n      <= final_res[WIDTH-1];
      o_z      <= (final_res == '0);
      o_c      <= co_nib;
      o_v      <= c3_nib ^ co_nib;
    end
  end

  // Status outputs decode straight from the state register
  always_comb begin
    o_busy = (state == RUN);
    o_done = (state == DONE);
  end
endmodule
